// File: rtl/st_control_sequencer.sv
// rtl/st_control_sequencer.sv - store-instruction control sequencer (fetch, EA add, MDR load, memory write)
module st_control_sequencer #(
  parameter logic [4:0]  ST_OPCODE   = 5'b00010,
  parameter logic [4:0]  ALU_INC     = 5'b11111,
  parameter logic [4:0]  ALU_ADD     = 5'b00011,
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input  logic        clock,
  input  logic        clear,
  input  logic        start,
  input  logic [31:0] ir,
  input  logic        mem_ready,
  output logic        PCOut,
  output logic        MARIn,
  output logic        ZIn,
  output logic        ZLoOut,
  output logic        PCIn,
  output logic        MDRIn,
  output logic        MDROut,
  output logic        IRIn,
  output logic        Gra,
  output logic        Grb,
  output logic        BAOut,
  output logic        ROut,
  output logic        YIn,
  output logic        COut,
  output logic        memread,
  output logic        memwrite,
  output logic [4:0]  ALUCode,
  output logic        busy,
  output logic        done,
  output logic        illegal,
  output logic        timeout
);

  typedef enum logic [3:0] {
    S_IDLE, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7, S_DONE, S_BAD, S_ERR
  } state_t;

  localparam logic [7:0] WAIT_LIMIT = 8'(MEM_TIMEOUT);

  state_t      state, state_n;
  logic [7:0]  wait_cnt, wait_cnt_n;
  logic [19:0] strobe_q, strobe_n;
  logic [4:0]  alu_q, alu_n;
  logic        ir_unused;

  assign ir_unused = ^ir[26:0];

  always_comb begin
    state_n    = state;
    wait_cnt_n = wait_cnt;
    case (state)
      S_IDLE: if (start) state_n = S_T0;
      S_T0: begin
        state_n    = S_T1;
        wait_cnt_n = 8'd0;
      end
      S_T1: begin
        if (mem_ready)                   state_n    = S_T2;
        else if (wait_cnt == WAIT_LIMIT) state_n    = S_ERR;
        else                             wait_cnt_n = wait_cnt + 8'd1;
      end
      S_T2: state_n = S_T3;
      S_T3: state_n = (ir[31:27] == ST_OPCODE) ? S_T4 : S_BAD;
      S_T4: state_n = S_T5;
      S_T5: state_n = S_T6;
      S_T6: begin
        state_n    = S_T7;
        wait_cnt_n = 8'd0;
      end
      S_T7: begin
        if (mem_ready)                   state_n    = S_DONE;
        else if (wait_cnt == WAIT_LIMIT) state_n    = S_ERR;
        else                             wait_cnt_n = wait_cnt + 8'd1;
      end
      default: state_n = S_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they register alongside it.
  // Bits: 0 PCOut 1 MARIn 2 ZIn 3 ZLoOut 4 PCIn 5 MDRIn 6 MDROut 7 IRIn 8 Gra 9 Grb
  //       10 BAOut 11 ROut 12 YIn 13 COut 14 memread 15 memwrite 16 busy 17 done 18 illegal 19 timeout
  always_comb begin
    strobe_n     = '0;
    alu_n        = 5'd0;
    strobe_n[16] = (state_n != S_IDLE);
    case (state_n)
      S_T0: begin
        strobe_n[2:0] = 3'b111;
        alu_n         = ALU_INC;
      end
      S_T1: begin
        strobe_n[3]  = (state == S_T0);
        strobe_n[4]  = (state == S_T0);
        strobe_n[5]  = 1'b1;
        strobe_n[14] = 1'b1;
      end
      S_T2: strobe_n[7:6] = 2'b11;
      S_T3: begin
        strobe_n[9]  = 1'b1;
        strobe_n[10] = 1'b1;
        strobe_n[12] = 1'b1;
      end
      S_T4: begin
        strobe_n[13] = 1'b1;
        strobe_n[2]  = 1'b1;
        alu_n        = ALU_ADD;
      end
      S_T5: begin
        strobe_n[3] = 1'b1;
        strobe_n[1] = 1'b1;
      end
      S_T6: begin
        strobe_n[8]  = 1'b1;
        strobe_n[11] = 1'b1;
        strobe_n[5]  = 1'b1;
      end
      S_T7:    strobe_n[15] = 1'b1;
      S_DONE:  strobe_n[17] = 1'b1;
      S_BAD:   strobe_n[18] = 1'b1;
      S_ERR:   strobe_n[19] = 1'b1;
      default: strobe_n[16] = 1'b0;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!clear) begin
      state    <= S_IDLE;
      wait_cnt <= 8'd0;
      strobe_q <= '0;
      alu_q    <= 5'd0;
    end else begin
      state    <= state_n;
      wait_cnt <= wait_cnt_n;
      strobe_q <= strobe_n;
      alu_q    <= alu_n;
    end
  end

  assign PCOut    = strobe_q[0];
  assign MARIn    = strobe_q[1];
  assign ZIn      = strobe_q[2];
  assign ZLoOut   = strobe_q[3];
  assign PCIn     = strobe_q[4];
  assign MDRIn    = strobe_q[5];
  assign MDROut   = strobe_q[6];
  assign IRIn     = strobe_q[7];
  assign Gra      = strobe_q[8];
  assign Grb      = strobe_q[9];
  assign BAOut    = strobe_q[10];
  assign ROut     = strobe_q[11];
  assign YIn      = strobe_q[12];
  assign COut     = strobe_q[13];
  assign memread  = strobe_q[14];
  assign memwrite = strobe_q[15];
  assign busy     = strobe_q[16];
  assign done     = strobe_q[17];
  assign illegal  = strobe_q[18];
  assign timeout  = strobe_q[19];
  assign ALUCode  = alu_q;

endmodule
